// File: rtl/rxd_pkg.sv
// rtl/rxd_pkg.sv - shared SoC types used by the data-bus arbiter
package rxd_pkg;

    // Identifies which bus master owns or is selected for a transaction.
    typedef enum logic {
        MASTER_0 = 1'b0,
        MASTER_1 = 1'b1
    } bus_master_t;

    // Arbiter state: idle, or one slave transaction outstanding.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arbiter_state_t;

endpackage

// File: rtl/ibex_bus_rr_select.sv
// rtl/ibex_bus_rr_select.sv - two-way round-robin pick for the bus arbiter
//
// Ports:
//   req[1:0]    request from master 1 (bit 1) and master 0 (bit 0)
//   last_owner  master granted most recently
//   sel         chosen master (meaningful only when valid)
//   valid       at least one master is requesting
module ibex_bus_rr_select
    import rxd_pkg::*;
(
    input  logic [1:0]  req,
    input  bus_master_t last_owner,
    output bus_master_t sel,
    output logic        valid
);

    always_comb begin
        valid = |req;
        sel   = MASTER_0;
        case (req)
            2'b01:   sel = MASTER_0;
            2'b10:   sel = MASTER_1;
            // Tie: the master that did not win last time goes next.
            2'b11:   sel = (last_owner == MASTER_0) ? MASTER_1 : MASTER_0;
            default: sel = MASTER_0;
        endcase
    end

endmodule

// File: rtl/ibex_bus_arbiter.sv
// rtl/ibex_bus_arbiter.sv - two-master round-robin arbiter for one Ibex data-bus slave
//
// Shares one slave port between master 0 and master 1 with a single
// outstanding transaction, steers rvalid/err back to the owner, broadcasts
// rdata, and returns an error response if the slave never answers.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   mX_req/we/be/addr/wdata          master request side
//   mX_gnt/rvalid/err/rdata          master grant and response side
//   s_req/we/be/addr/wdata           slave request side
//   s_gnt/rvalid/err/rdata           slave grant and response side
module ibex_bus_arbiter
    import rxd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        s_req,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_gnt,
    input  logic        s_rvalid,
    input  logic        s_err,
    input  logic [31:0] s_rdata
);

    localparam int unsigned         CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arbiter_state_t     r_state;
    bus_master_t        r_owner;
    bus_master_t        r_last_owner;
    bus_master_t        r_hold_sel;
    logic               r_hold;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_drop_pending;

    bus_master_t        w_rr_sel;
    logic               w_rr_valid;
    bus_master_t        w_sel;
    logic               w_busy;
    logic               w_resp;
    logic               w_timeout;
    logic               w_rsp_valid;
    logic               w_rsp_err;
    logic               w_accept;
    logic               w_sel_req;
    logic               w_s_req;
    logic               w_fire;

    ibex_bus_rr_select u_rr_select (
        .req        ({m1_req, m0_req}),
        .last_owner (r_last_owner),
        .sel        (w_rr_sel),
        .valid      (w_rr_valid)
    );

    assign w_busy      = (r_state == ARB_BUSY);
    assign w_resp      = w_busy & s_rvalid;
    // A response arriving on the terminal count wins over the timeout.
    assign w_timeout   = w_busy & ~s_rvalid & (r_cnt == CNT_LAST);
    assign w_rsp_valid = w_resp | w_timeout;
    assign w_rsp_err   = w_resp ? s_err : 1'b1;

    // rst_n gates the request path so the slave sees s_req fall as soon as
    // reset asserts, not at the next clock.
    assign w_accept    = rst_n & ~r_drop_pending & (~w_busy | s_rvalid);

    // A master stalled by s_gnt keeps the slot even if the other master
    // starts requesting and would win the round-robin tie.
    assign w_sel       = r_hold ? r_hold_sel : w_rr_sel;
    assign w_sel_req   = (w_sel == MASTER_1) ? m1_req : m0_req;
    assign w_s_req     = w_accept & w_rr_valid & w_sel_req;
    assign w_fire      = w_s_req & s_gnt;

    always_comb begin
        s_req   = w_s_req;
        s_we    = 1'b0;
        s_be    = '0;
        s_addr  = '0;
        s_wdata = '0;
        if (w_s_req) begin
            if (w_sel == MASTER_1) begin
                s_we    = m1_we;
                s_be    = m1_be;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
            end else begin
                s_we    = m0_we;
                s_be    = m0_be;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
            end
        end
    end

    assign m0_gnt    = w_fire & (w_sel == MASTER_0);
    assign m1_gnt    = w_fire & (w_sel == MASTER_1);

    assign m0_rvalid = w_rsp_valid & (r_owner == MASTER_0);
    assign m1_rvalid = w_rsp_valid & (r_owner == MASTER_1);
    assign m0_err    = m0_rvalid & w_rsp_err;
    assign m1_err    = m1_rvalid & w_rsp_err;

    // Read data is shared; it is zero when idle and on a timeout response.
    assign m0_rdata  = (w_busy & ~w_timeout) ? s_rdata : '0;
    assign m1_rdata  = (w_busy & ~w_timeout) ? s_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ARB_IDLE;
            r_owner        <= MASTER_0;
            r_last_owner   <= MASTER_1;
            r_hold_sel     <= MASTER_0;
            r_hold         <= 1'b0;
            r_cnt          <= '0;
            r_drop_pending <= 1'b0;
        end else begin
            r_hold     <= w_s_req & ~s_gnt;
            r_hold_sel <= w_sel;

            if (w_fire) begin
                r_owner      <= w_sel;
                r_last_owner <= w_sel;
                r_cnt        <= '0;
                r_state      <= ARB_BUSY;
            end else if (w_rsp_valid) begin
                r_state      <= ARB_IDLE;
            end else if (w_busy) begin
                r_cnt        <= r_cnt + 1'b1;
            end

            // The timed-out slave may still answer later; that stray
            // response must be swallowed before the bus is reused.
            if (w_timeout) begin
                r_drop_pending <= 1'b1;
            end else if (r_drop_pending & s_rvalid) begin
                r_drop_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ibex_bus_arbiter.sv
// tb/tb_ibex_bus_arbiter.sv - self-checking bench for ibex_bus_arbiter
module tb_ibex_bus_arbiter;

    localparam logic [31:0] A0  = 32'h0010_0004;
    localparam logic [31:0] A1  = 32'h2000_0008;
    localparam logic [3:0]  BE0 = 4'hF;
    localparam logic [3:0]  BE1 = 4'h3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_gnt, s_rvalid, s_err;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int n_cmp  = 0;
    int n_fail = 0;
    logic sb_q[$];

    always #5 clk = ~clk;

    ibex_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata)
    );

    typedef struct {
        logic        m0_req, m1_req, m1_we, s_gnt, s_rvalid, s_err;
        logic [31:0] s_rdata;
        logic        e_s_req, e_sel, e_m0_gnt, e_m1_gnt, e_m0_rv, e_m1_rv, e_m0_err, e_m1_err;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic m0r, m1r, we, sg, srv, se, input logic [31:0] rd,
                                input logic esq, esel, eg0, eg1, erv0, erv1, ee0, ee1,
                                input logic [31:0] erd);
        vec_t v;
        v.m0_req = m0r; v.m1_req = m1r; v.m1_we = we; v.s_gnt = sg; v.s_rvalid = srv;
        v.s_err = se; v.s_rdata = rd; v.e_s_req = esq; v.e_sel = esel;
        v.e_m0_gnt = eg0; v.e_m1_gnt = eg1; v.e_m0_rv = erv0; v.e_m1_rv = erv1;
        v.e_m0_err = ee0; v.e_m1_err = ee1; v.e_rdata = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus just after a rising edge, check at the
    // falling edge, then advance to just after the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        m0_req = v.m0_req; m1_req = v.m1_req; m1_we = v.m1_we;
        s_gnt = v.s_gnt; s_rvalid = v.s_rvalid; s_err = v.s_err; s_rdata = v.s_rdata;
        e_addr = v.e_s_req ? (v.e_sel ? A1 : A0) : 32'h0;
        e_be   = v.e_s_req ? (v.e_sel ? BE1 : BE0) : 4'h0;
        e_we   = v.e_s_req & v.e_sel & v.m1_we;
        #4;
        chk({tag, ".s_req"},     32'(s_req),     32'(v.e_s_req));
        chk({tag, ".s_addr"},    s_addr,         e_addr);
        chk({tag, ".s_be"},      32'(s_be),      32'(e_be));
        chk({tag, ".s_we"},      32'(s_we),      32'(e_we));
        chk({tag, ".m0_gnt"},    32'(m0_gnt),    32'(v.e_m0_gnt));
        chk({tag, ".m1_gnt"},    32'(m1_gnt),    32'(v.e_m1_gnt));
        chk({tag, ".m0_rvalid"}, 32'(m0_rvalid), 32'(v.e_m0_rv));
        chk({tag, ".m1_rvalid"}, 32'(m1_rvalid), 32'(v.e_m1_rv));
        chk({tag, ".m0_err"},    32'(m0_err),    32'(v.e_m0_err));
        chk({tag, ".m1_err"},    32'(m1_err),    32'(v.e_m1_err));
        chk({tag, ".m0_rdata"},  m0_rdata,       v.e_rdata);
        chk({tag, ".m1_rdata"},  m1_rdata,       v.e_rdata);
        // Scoreboard: each response must go to the owner recorded at grant.
        if (m0_rvalid || m1_rvalid) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL %s.sb_empty: got response on m%0d want none pending", tag, m1_rvalid);
            end else begin
                chk({tag, ".sb_owner"}, 32'(m1_rvalid), 32'(sb_q.pop_front()));
            end
        end
        if (v.s_gnt && v.e_m0_gnt) sb_q.push_back(1'b0);
        if (v.s_gnt && v.e_m1_gnt) sb_q.push_back(1'b1);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[15];

    initial begin
        rst_n = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
        m0_be = BE0; m1_be = BE1; m0_addr = A0; m1_addr = A1;
        m0_wdata = 32'h0000_1111; m1_wdata = 32'h0000_2222;
        s_gnt = 1'b1; s_rvalid = 1'b1; s_err = 1'b1; s_rdata = 32'h5555_AAAA;

        //            m0 m1 we sg rv se rdata          sq sl g0 g1 v0 v1 e0 e1 erdata
        tbl[0]  = mk(1, 0, 0, 1, 0, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        tbl[1]  = mk(0, 0, 0, 0, 1, 0, 32'hDEADBEEF,   0, 0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 32'h0,          1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        tbl[3]  = mk(1, 1, 0, 0, 0, 0, 32'h0,          1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        tbl[4]  = mk(1, 1, 0, 0, 0, 0, 32'h0,          1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        tbl[5]  = mk(1, 1, 0, 1, 0, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        tbl[6]  = mk(0, 1, 0, 1, 1, 0, 32'hA5A5A5A5,   1, 1, 0, 1, 1, 0, 0, 0, 32'hA5A5A5A5);
        tbl[7]  = mk(1, 1, 0, 1, 1, 0, 32'h11,         1, 0, 1, 0, 0, 1, 0, 0, 32'h11);
        tbl[8]  = mk(1, 1, 0, 1, 1, 0, 32'h22,         1, 1, 0, 1, 1, 0, 0, 0, 32'h22);
        tbl[9]  = mk(1, 1, 0, 1, 1, 0, 32'h33,         1, 0, 1, 0, 0, 1, 0, 0, 32'h33);
        tbl[10] = mk(1, 1, 0, 1, 1, 0, 32'h44,         1, 1, 0, 1, 1, 0, 0, 0, 32'h44);
        tbl[11] = mk(0, 0, 0, 0, 1, 0, 32'h55,         0, 0, 0, 0, 0, 1, 0, 0, 32'h55);
        tbl[12] = mk(0, 1, 1, 1, 0, 0, 32'h0,          1, 1, 0, 1, 0, 0, 0, 0, 32'h0);
        tbl[13] = mk(0, 0, 0, 0, 1, 1, 32'h0,          0, 0, 0, 0, 0, 1, 0, 1, 32'h0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

        // Reset state, with requests and slave handshakes driven high.
        @(posedge clk); #1;
        @(posedge clk); #4;
        chk("rst.s_req",     32'(s_req),     32'h0);
        chk("rst.m0_gnt",    32'(m0_gnt),    32'h0);
        chk("rst.m1_gnt",    32'(m1_gnt),    32'h0);
        chk("rst.m0_rvalid", 32'(m0_rvalid), 32'h0);
        chk("rst.m1_rvalid", 32'(m1_rvalid), 32'h0);
        chk("rst.m0_rdata",  m0_rdata,       32'h0);
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b0; s_err = 1'b0; s_rdata = 32'h0;
        rst_n = 1'b1;

        // Single master, slave stall with late M1 request, contention, error.
        for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Timeout: grant to M0, slave silent; error response 16 cycles later.
        apply(mk(1, 0, 0, 1, 0, 0, 32'h0, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0), "to.gnt");
        for (int k = 1; k <= 16; k++) begin
            if (k < 16)
                apply(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0),
                      $sformatf("to.wait%0d", k));
            else
                apply(mk(0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0), "to.resp");
        end
        // No grant while the stray response is still owed.
        for (int k = 17; k <= 19; k++)
            apply(mk(1, 0, 0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0),
                  $sformatf("to.blk%0d", k));
        apply(mk(1, 0, 0, 1, 1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0), "to.drop");
        apply(mk(1, 0, 0, 1, 0, 0, 32'h0, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0), "to.regnt");
        apply(mk(0, 0, 0, 0, 1, 0, 32'hCAFE0001, 0, 0, 0, 0, 1, 0, 0, 0, 32'hCAFE0001), "to.rsp2");

        // Reset one cycle after a grant to M1 abandons the transaction.
        apply(mk(0, 1, 0, 1, 0, 0, 32'h0, 1, 1, 0, 1, 0, 0, 0, 0, 32'h0), "rb.gnt");
        m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h7777_0000;
        rst_n = 1'b0;
        #1;
        chk("rb.s_req",     32'(s_req),     32'h0);
        chk("rb.m0_gnt",    32'(m0_gnt),    32'h0);
        chk("rb.m1_gnt",    32'(m1_gnt),    32'h0);
        chk("rb.m1_rvalid", 32'(m1_rvalid), 32'h0);
        chk("rb.m0_rvalid", 32'(m0_rvalid), 32'h0);
        chk("rb.m1_rdata",  m1_rdata,       32'h0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(mk(1, 1, 0, 1, 0, 0, 32'h0, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0), "rb.tie");
        apply(mk(0, 0, 0, 0, 1, 0, 32'h0BADF00D, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0BADF00D), "rb.rsp");

        chk("sb.drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
